// File: rtl/stack_op_sequencer.sv
// Stack operation sequencer: bus master that turns push/pop/load/read commands
// for two hardware stacks into 8-bit bus cycles on the stack control window and
// the stack frame window, tracking per-stack depth so overflow and underflow are
// rejected before any bus traffic.
module stack_op_sequencer #(
  parameter logic [15:0] CTRL_BASE     = 16'hFC00,
  parameter logic [15:0] FRAME_BASE    = 16'hC000,
  parameter int          DEPTH         = 256,
  parameter int          STROBE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_sel,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic [15:0] a,
  output logic [7:0]  d_out,
  input  logic [7:0]  d_in,
  output logic        n_we,
  output logic        n_oe,
  output logic [8:0]  depth_0,
  output logic [8:0]  depth_1
);

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_DECODE, ST_SETUP, ST_STROBE, ST_DONE, ST_ERR
  } state_t;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00, OP_POP = 2'b01, OP_LOAD = 2'b10, OP_READ = 2'b11
  } op_t;

  // One bus access: where, what to write, whether it is a read, and whether it
  // is the final access of the command.
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rd;
    logic        last;
  } acc_t;

  localparam logic [8:0] LP_DEPTH       = 9'(DEPTH);
  localparam logic [1:0] LP_STROBE_LAST = 2'(STROBE_CYCLES - 1);

  // Access plan for a command step. Push pre-decrements the hardware SP before
  // writing the slot; pop reads the slot and then post-increments the SP.
  function automatic acc_t acc_plan(input logic init, input op_t op, input logic sel,
                                    input logic step, input logic [7:0] wdata);
    acc_t        p;
    logic [15:0] slot;
    logic [15:0] ctrl_sp;
    slot    = FRAME_BASE | {4'b0000, sel, 11'b0};
    ctrl_sp = CTRL_BASE + {15'b0, sel};
    // NOTE: every field gets a default before the case, so no path leaves a
    // value undefined and combinational users never infer storage.
    p = '{addr: CTRL_BASE + 16'd3, data: 8'h01, rd: 1'b0, last: 1'b1};
    if (!init) begin
      case (op)
        OP_PUSH: begin
          if (!step) p = '{addr: CTRL_BASE + 16'd2, data: (sel ? 8'hF7 : 8'hFB),
                           rd: 1'b0, last: 1'b0};
          else       p = '{addr: slot, data: wdata, rd: 1'b0, last: 1'b1};
        end
        OP_POP: begin
          if (!step) p = '{addr: slot, data: 8'h00, rd: 1'b1, last: 1'b0};
          else       p = '{addr: CTRL_BASE + 16'd2, data: (sel ? 8'hFD : 8'hFE),
                           rd: 1'b0, last: 1'b1};
        end
        OP_LOAD: p = '{addr: ctrl_sp, data: wdata, rd: 1'b0, last: 1'b1};
        OP_READ: p = '{addr: ctrl_sp, data: 8'h00, rd: 1'b1, last: 1'b1};
      endcase
    end
    return p;
  endfunction

  state_t      r_state;
  op_t         r_op;
  logic        r_sel;
  logic [7:0]  r_data;
  logic        r_init;
  acc_t        r_acc;
  logic [1:0]  r_cnt;
  logic [7:0]  r_rdata;
  logic        r_cmd_ready;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [7:0]  r_rsp_data;
  logic        r_n_we;
  logic        r_n_oe;
  logic [8:0]  r_depth_0;
  logic [8:0]  r_depth_1;

  acc_t        w_first;
  acc_t        w_next;
  logic [8:0]  w_depth_sel;
  logic        w_reject;

  assign w_first     = acc_plan(r_init, r_op, r_sel, 1'b0, r_data);
  assign w_next      = acc_plan(r_init, r_op, r_sel, 1'b1, r_data);
  assign w_depth_sel = r_sel ? r_depth_1 : r_depth_0;
  assign w_reject    = ((r_op == OP_PUSH) && (w_depth_sel == LP_DEPTH)) ||
                       ((r_op == OP_POP)  && (w_depth_sel == 9'd0));

  // Sequencer FSM: all bus and handshake outputs are registered here.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= ST_INIT;
      r_op        <= OP_PUSH;
      r_sel       <= 1'b0;
      r_data      <= 8'h00;
      r_init      <= 1'b1;
      r_acc       <= '0;
      r_cnt       <= 2'd0;
      r_rdata     <= 8'h00;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_n_we      <= 1'b1;
      r_n_oe      <= 1'b1;
      r_depth_0   <= 9'd0;
      r_depth_1   <= 9'd0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every decision below sees
      // the state as it was before this edge.
      case (r_state)
        ST_INIT: begin
          r_acc   <= w_first;
          r_state <= ST_SETUP;
        end
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op        <= op_t'(cmd_op);
            r_sel       <= cmd_sel;
            r_data      <= cmd_data;
            r_cmd_ready <= 1'b0;
            r_state     <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_reject) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_data  <= 8'h00;
            r_state     <= ST_ERR;
          end else begin
            r_acc   <= w_first;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_n_we  <= r_acc.rd;
          r_n_oe  <= ~r_acc.rd;
          r_cnt   <= LP_STROBE_LAST;
          r_state <= ST_STROBE;
        end
        ST_STROBE: begin
          if (r_cnt != 2'd0) begin
            r_cnt <= r_cnt - 2'd1;
          end else begin
            // Strobe ends here; the address only moves on this same edge or later.
            r_n_we <= 1'b1;
            r_n_oe <= 1'b1;
            if (r_acc.rd) r_rdata <= d_in;
            if (!r_acc.last) begin
              r_acc   <= w_next;
              r_state <= ST_SETUP;
            end else if (r_init) begin
              r_init      <= 1'b0;
              r_cmd_ready <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_rsp_valid <= 1'b1;
              if (r_acc.rd)             r_rsp_data <= d_in;
              else if (r_op == OP_POP)  r_rsp_data <= r_rdata;
              else                      r_rsp_data <= 8'h00;
              case (r_op)
                OP_PUSH: if (r_sel) r_depth_1 <= r_depth_1 + 9'd1;
                         else       r_depth_0 <= r_depth_0 + 9'd1;
                OP_POP:  if (r_sel) r_depth_1 <= r_depth_1 - 9'd1;
                         else       r_depth_0 <= r_depth_0 - 9'd1;
                OP_LOAD: if (r_sel) r_depth_1 <= 9'd0;
                         else       r_depth_0 <= 9'd0;
                default: ;
              endcase
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE, ST_ERR: begin
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_data  <= 8'h00;
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_data  = r_rsp_data;
  assign a         = r_acc.addr;
  assign d_out     = r_acc.data;
  assign n_we      = r_n_we;
  assign n_oe      = r_n_oe;
  assign depth_0   = r_depth_0;
  assign depth_1   = r_depth_1;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Testbench for stack_op_sequencer (DEPTH=2, STROBE_CYCLES=1): table of
// commands with hand-computed bus traffic, latency, response and depths, plus
// directed reset/INIT and reset-during-pop sequences.
module tb_stack_op_sequencer;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic        cmd_sel = 1'b0;
  logic [7:0]  cmd_data = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [15:0] a;
  logic [7:0]  d_out;
  logic [7:0]  d_in = 8'h00;
  logic        n_we;
  logic        n_oe;
  logic [8:0]  depth_0;
  logic [8:0]  depth_1;

  stack_op_sequencer #(
    .CTRL_BASE(16'hFC00), .FRAME_BASE(16'hC000), .DEPTH(2), .STROBE_CYCLES(1)
  ) dut (
    .clk(clk), .n_rst(n_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .a(a), .d_out(d_out), .d_in(d_in), .n_we(n_we), .n_oe(n_oe),
    .depth_0(depth_0), .depth_1(depth_1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] a;
    logic [7:0]  d;
  } bus_rec_t;

  typedef struct {
    logic [1:0]  op;
    logic        sel;
    logic [7:0]  data;
    logic [7:0]  din;
    logic        err;
    logic [7:0]  rdata;
    int          lat;
    int          nacc;
    logic [8:0]  d0;
    logic [8:0]  d1;
    bus_rec_t    acc0;
    bus_rec_t    acc1;
  } vec_t;

  int       n_checks = 0;
  int       n_fail = 0;
  bus_rec_t bus_q[$];
  int       strobe_cycles = 0;
  int       viol = 0;
  int       rsp_count = 0;
  logic     prev_low = 1'b0;
  logic     cur_low;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Bus monitor: logs each strobe pulse with the address/data seen at its start.
  always @(negedge clk) begin
    cur_low = !n_we || !n_oe;
    if (cur_low && !prev_low) bus_q.push_back('{we: !n_we, a: a, d: d_out});
    if (cur_low) strobe_cycles++;
    if (cur_low && prev_low && bus_q.size() > 0 && a !== bus_q[bus_q.size()-1].a) viol++;
    if (!n_we && !n_oe) viol++;
    if (rsp_valid) rsp_count++;
    prev_low = cur_low;
  end

  task automatic reset_and_init(input string tag);
    n_rst = 1'b0;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_rst_nwe"}, n_we, 1);
    check({tag, "_rst_noe"}, n_oe, 1);
    check({tag, "_rst_a"}, a, 0);
    check({tag, "_rst_dout"}, d_out, 0);
    check({tag, "_rst_ready"}, cmd_ready, 0);
    check({tag, "_rst_rsp"}, {rsp_valid, rsp_err, rsp_data}, 0);
    check({tag, "_rst_depth"}, {depth_0, depth_1}, 0);
    n_rst = 1'b1;
    @(posedge clk); #1;
    check({tag, "_init_a"}, a, 32'hFC03);
    check({tag, "_init_dout"}, d_out, 32'h01);
    check({tag, "_init_setup_nwe"}, n_we, 1);
    @(posedge clk); #1;
    check({tag, "_init_strobe_nwe"}, {n_we, n_oe}, 2'b01);
    check({tag, "_init_ready_lo"}, cmd_ready, 0);
    @(posedge clk); #1;
    check({tag, "_init_end_nwe"}, n_we, 1);
    check({tag, "_init_ready_hi"}, cmd_ready, 1);
    bus_q.delete();
    strobe_cycles = 0;
  endtask

  task automatic issue(input logic [1:0] op, input logic sel, input logic [7:0] data,
                       input string tag);
    int w;
    @(negedge clk);
    w = 0;
    while (cmd_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready"}, cmd_ready, 1);
    cmd_op = op;
    cmd_sel = sel;
    cmd_data = data;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int  lat;
    bit  got;
    bus_q.delete();
    strobe_cycles = 0;
    d_in = v.din;
    issue(v.op, v.sel, v.data, tag);
    lat = 0;
    got = 0;
    while (!got && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (rsp_valid === 1'b1) got = 1;
    end
    check({tag, "_lat"}, lat, v.lat);
    check({tag, "_err"}, rsp_err, v.err);
    check({tag, "_rdata"}, rsp_data, v.rdata);
    check({tag, "_depth0"}, depth_0, v.d0);
    check({tag, "_depth1"}, depth_1, v.d1);
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, {rsp_valid, cmd_ready}, 2'b01);
    check({tag, "_nacc"}, bus_q.size(), v.nacc);
    check({tag, "_strobes"}, strobe_cycles, v.nacc);
    if (v.nacc >= 1 && bus_q.size() >= 1) begin
      check({tag, "_acc0_we_a"}, {bus_q[0].we, bus_q[0].a}, {v.acc0.we, v.acc0.a});
      if (v.acc0.we) check({tag, "_acc0_d"}, bus_q[0].d, v.acc0.d);
    end
    if (v.nacc >= 2 && bus_q.size() >= 2) begin
      check({tag, "_acc1_we_a"}, {bus_q[1].we, bus_q[1].a}, {v.acc1.we, v.acc1.a});
      if (v.acc1.we) check({tag, "_acc1_d"}, bus_q[1].d, v.acc1.d);
    end
  endtask

  localparam bus_rec_t NONE = '{we: 1'b0, a: 16'h0000, d: 8'h00};
  vec_t vecs[13];

  initial begin
    int w;
    int rsp_before;
    // op sel data din | err rdata lat nacc d0 d1 | acc0 acc1
    vecs[0]  = '{2'b00, 1'b0, 8'h5A, 8'h00, 1'b0, 8'h00, 5, 2, 9'd1, 9'd0,
                 '{1'b1, 16'hFC02, 8'hFB}, '{1'b1, 16'hC000, 8'h5A}};
    vecs[1]  = '{2'b01, 1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 1, 0, 9'd1, 9'd0, NONE, NONE};
    vecs[2]  = '{2'b00, 1'b1, 8'hA5, 8'h00, 1'b0, 8'h00, 5, 2, 9'd1, 9'd1,
                 '{1'b1, 16'hFC02, 8'hF7}, '{1'b1, 16'hC800, 8'hA5}};
    vecs[3]  = '{2'b01, 1'b1, 8'h00, 8'hA5, 1'b0, 8'hA5, 5, 2, 9'd1, 9'd0,
                 '{1'b0, 16'hC800, 8'h00}, '{1'b1, 16'hFC02, 8'hFD}};
    vecs[4]  = '{2'b00, 1'b0, 8'h11, 8'h00, 1'b0, 8'h00, 5, 2, 9'd2, 9'd0,
                 '{1'b1, 16'hFC02, 8'hFB}, '{1'b1, 16'hC000, 8'h11}};
    vecs[5]  = '{2'b00, 1'b0, 8'h22, 8'h00, 1'b1, 8'h00, 1, 0, 9'd2, 9'd0, NONE, NONE};
    vecs[6]  = '{2'b10, 1'b0, 8'h33, 8'h00, 1'b0, 8'h00, 3, 1, 9'd0, 9'd0,
                 '{1'b1, 16'hFC00, 8'h33}, NONE};
    vecs[7]  = '{2'b11, 1'b1, 8'h00, 8'h3C, 1'b0, 8'h3C, 3, 1, 9'd0, 9'd0,
                 '{1'b0, 16'hFC01, 8'h00}, NONE};
    vecs[8]  = '{2'b01, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1, 0, 9'd0, 9'd0, NONE, NONE};
    vecs[9]  = '{2'b00, 1'b1, 8'h77, 8'h00, 1'b0, 8'h00, 5, 2, 9'd0, 9'd1,
                 '{1'b1, 16'hFC02, 8'hF7}, '{1'b1, 16'hC800, 8'h77}};
    vecs[10] = '{2'b01, 1'b1, 8'h00, 8'hC3, 1'b0, 8'hC3, 5, 2, 9'd0, 9'd0,
                 '{1'b0, 16'hC800, 8'h00}, '{1'b1, 16'hFC02, 8'hFD}};
    vecs[11] = '{2'b00, 1'b1, 8'h44, 8'h00, 1'b0, 8'h00, 5, 2, 9'd0, 9'd1,
                 '{1'b1, 16'hFC02, 8'hF7}, '{1'b1, 16'hC800, 8'h44}};
    vecs[12] = '{2'b10, 1'b1, 8'h9A, 8'h00, 1'b0, 8'h00, 3, 1, 9'd0, 9'd0,
                 '{1'b1, 16'hFC01, 8'h9A}, NONE};

    reset_and_init("boot");

    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset while a pop is strobing: strobe must rise at once, no response follows.
    run_vec('{2'b00, 1'b0, 8'h66, 8'h00, 1'b0, 8'h00, 5, 2, 9'd1, 9'd0,
              '{1'b1, 16'hFC02, 8'hFB}, '{1'b1, 16'hC000, 8'h66}}, "pre_rst_push");
    d_in = 8'h66;
    issue(2'b01, 1'b0, 8'h00, "rst_pop");
    w = 0;
    while (n_oe !== 1'b0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("rst_pop_strobe_seen", n_oe, 0);
    rsp_before = rsp_count;
    #1 n_rst = 1'b0;
    #1;
    check("rst_pop_noe_async", {n_oe, n_we}, 2'b11);
    check("rst_pop_a_async", a, 0);
    reset_and_init("rerun");
    repeat (3) @(negedge clk);
    check("rst_pop_no_rsp", rsp_count, rsp_before);

    check("a_stable_during_strobe", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
